// File: rtl/en_rowshift_subbyte_seq_pkg.sv
// Shared AES constants, FSM encoding and the forward ShiftRows byte map for the
// encrypt-side ShiftRows/SubBytes stage.
package en_rowshift_subbyte_seq_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NB      = 4;
  localparam int AES_WORD_W  = AES_BYTE_W * AES_NB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_DRAIN,
    ST_OUT
  } state_t;

  // Output byte k takes input byte SR_IDX[k]; byte 0 is the MSB, column-major.
  localparam int SR_IDX [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] blk);
    logic [AES_BLOCK_W-1:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) begin
      res[AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W] =
        blk[AES_BLOCK_W-1-AES_BYTE_W*SR_IDX[k] -: AES_BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/en_rowshift_subbyte_seq_if.sv
// Valid/ready bus of the ShiftRows/SubBytes stage: one input channel, one output channel.
interface en_rowshift_subbyte_seq_if;
  import en_rowshift_subbyte_seq_pkg::*;

  logic                   iInValid;
  logic                   oInReady;
  logic [AES_BLOCK_W-1:0] iBlockIn;
  logic                   oOutValid;
  logic                   iOutReady;
  logic [AES_BLOCK_W-1:0] oBlockOut;

  modport slave (
    input  iInValid, iBlockIn, iOutReady,
    output oInReady, oOutValid, oBlockOut
  );

  modport master (
    output iInValid, iBlockIn, iOutReady,
    input  oInReady, oOutValid, oBlockOut
  );
endinterface

// File: rtl/en_rowshift_subbyte_seq_rom.sv
// Forward AES S-box, 256x8, two read ports with registered outputs (1-cycle latency).
module rom_2p_en
  import en_rowshift_subbyte_seq_pkg::*;
(
  input  logic                  clk,
  input  logic [AES_BYTE_W-1:0] addr_a,
  input  logic [AES_BYTE_W-1:0] addr_b,
  output logic [AES_BYTE_W-1:0] q_a,
  output logic [AES_BYTE_W-1:0] q_b
);

  localparam logic [0:255][AES_BYTE_W-1:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_ff @(posedge clk) begin
    q_a <= SBOX[addr_a];
    q_b <= SBOX[addr_b];
  end

endmodule

// File: rtl/en_rowshift_subbyte_seq.sv
// Encrypt-side ShiftRows + SubBytes stage: shift at capture, then four beats of
// four S-box lookups, one drain beat for ROM latency, and a held output.
module en_rowshift_subbyte_seq
  import en_rowshift_subbyte_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  en_rowshift_subbyte_seq_if.slave bus
);

  state_t                 state_p0;
  logic [1:0]             beat_p0;
  logic [AES_BLOCK_W-1:0] cap_p0;
  logic [AES_WORD_W-1:0]  word_p0;
  logic                   vld_p1;
  logic [1:0]             beat_p1;
  logic [AES_WORD_W-1:0]  q_p1;
  logic [AES_BLOCK_W-1:0] res_p1;
  logic [AES_BLOCK_W-1:0] out_p2;
  logic                   out_vld;
  logic                   accept;

  assign bus.oInReady  = (state_p0 == ST_IDLE) || ((state_p0 == ST_OUT) && bus.iOutReady);
  assign accept        = bus.iInValid && bus.oInReady;
  assign bus.oOutValid = out_vld;
  assign bus.oBlockOut = out_p2;

  // Stage p0 -> p1: current capture word addresses the two dual-port ROMs.
  assign word_p0 = cap_p0[AES_WORD_W*(AES_NB-1-int'(beat_p0)) +: AES_WORD_W];

  rom_2p_en u_rom_lo (
    .clk    (clk),
    .addr_a (word_p0[31:24]),
    .addr_b (word_p0[23:16]),
    .q_a    (q_p1[31:24]),
    .q_b    (q_p1[23:16])
  );

  rom_2p_en u_rom_hi (
    .clk    (clk),
    .addr_a (word_p0[15:8]),
    .addr_b (word_p0[7:0]),
    .q_a    (q_p1[15:8]),
    .q_b    (q_p1[7:0])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ST_IDLE;
      beat_p0  <= 2'd0;
      cap_p0   <= '0;
      vld_p1   <= 1'b0;
      beat_p1  <= 2'd0;
      res_p1   <= '0;
      out_p2   <= '0;
      out_vld  <= 1'b0;
    end else begin
      // Stage p1: ROM data for the beat issued last cycle lands in the result word.
      vld_p1  <= (state_p0 == ST_SUB);
      beat_p1 <= beat_p0;
      if (vld_p1) begin
        res_p1[AES_WORD_W*(AES_NB-1-int'(beat_p1)) +: AES_WORD_W] <= q_p1;
      end

      case (state_p0)
        ST_IDLE: begin
          if (accept) begin
            cap_p0   <= shift_rows(bus.iBlockIn);
            beat_p0  <= 2'd0;
            state_p0 <= ST_SUB;
          end
        end
        ST_SUB: begin
          beat_p0 <= beat_p0 + 2'd1;
          if (beat_p0 == 2'd3) state_p0 <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Stage p2: last word comes straight from the ROM so the output only moves here.
          out_p2   <= {res_p1[AES_BLOCK_W-1:AES_WORD_W], q_p1};
          out_vld  <= 1'b1;
          state_p0 <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.iOutReady) begin
            out_vld <= 1'b0;
            if (bus.iInValid) begin
              cap_p0   <= shift_rows(bus.iBlockIn);
              beat_p0  <= 2'd0;
              state_p0 <= ST_SUB;
            end else begin
              state_p0 <= ST_IDLE;
            end
          end
        end
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_en_rowshift_subbyte_seq.sv
// Directed and randomized checks of the encrypt ShiftRows/SubBytes stage against an
// S-box derived from GF(2^8) inversion plus the affine map.
module tb_en_rowshift_subbyte_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  en_rowshift_subbyte_seq_if bus ();

  en_rowshift_subbyte_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];
  int srb [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[sb[x]] = 8'(x);
    end
  endtask

  function automatic logic [127:0] fwd_model(input logic [127:0] blk);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sb[blk[127-8*srb[k] -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] inv_model(input logic [127:0] blk);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*srb[k] -: 8] = isb[blk[127-8*k -: 8]];
    return r;
  endfunction

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] blk);
    @(negedge clk);
    bus.iBlockIn = blk;
    bus.iInValid = 1'b1;
    chk1("in_ready_idle", bus.oInReady, 1'b1);
    @(posedge clk);
  endtask

  // Called just after the acceptance edge; lat counts that edge as 1.
  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    bus.iInValid  = 1'b0;
    bus.iOutReady = 1'b0;
    while (!bus.oOutValid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.iOutReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.iOutReady = 1'b0;
    chk1("valid_drop_after_take", bus.oOutValid, 1'b0);
  endtask

  task automatic run_stream(input int nblk, input bit rand_hs, input bit inv_chk);
    logic [127:0] q[$];
    logic [127:0] exp;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < nblk && cyc < 20000) begin
      @(negedge clk);
      bus.iInValid  = (sent < nblk) && (rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.iBlockIn  = {$urandom, $urandom, $urandom, $urandom};
      bus.iOutReady = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (bus.iInValid && bus.oInReady) begin
        q.push_back(bus.iBlockIn);
        sent++;
      end
      if (bus.oOutValid && bus.iOutReady) begin
        n_assert++;
        assert (q.size() > 0) else begin
          n_fail++;
          $error("FAIL stream_extra_output: observed %h expected none", bus.oBlockOut);
        end
        if (q.size() > 0) begin
          exp = q.pop_front();
          if (inv_chk) chk128("inv_chain_recover", inv_model(bus.oBlockOut), exp);
          else         chk128("stream_block", bus.oBlockOut, fwd_model(exp));
        end
        got++;
      end
      @(posedge clk);
      cyc++;
    end
    chk_int("stream_received", got, nblk);
    chk_int("stream_leftover", q.size(), 0);
    @(negedge clk);
    bus.iInValid  = 1'b0;
    bus.iOutReady = 1'b0;
  endtask

  logic [127:0] held, exp_b;
  int lat;

  initial begin
    build_sbox();
    bus.iInValid  = 1'b0;
    bus.iOutReady = 1'b0;
    bus.iBlockIn  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset_out_valid", bus.oOutValid, 1'b0);
    chk128("reset_block_out", bus.oBlockOut, 128'h0);
    chk1("reset_in_ready", bus.oInReady, 1'b1);
    rst_n = 1'b1;

    // FIPS-197 round-1 vector and latency
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    wait_out(lat);
    chk_int("fips_latency", lat, 6);
    chk128("fips_block", bus.oBlockOut, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk1("in_ready_out_blocked", bus.oInReady, 1'b0);
    consume();

    send(128'h0);
    wait_out(lat);
    chk128("zero_block", bus.oBlockOut, {16{8'h63}});
    consume();
    send({16{8'h01}});
    wait_out(lat);
    chk128("ones_block", bus.oBlockOut, {16{8'h7c}});
    consume();

    // Back-pressure hold, then release with a new block on the same edge
    send(128'h00112233445566778899aabbccddeeff);
    wait_out(lat);
    held = bus.oBlockOut;
    chk128("hold_first", held, fwd_model(128'h00112233445566778899aabbccddeeff));
    bus.iInValid = 1'b1;
    bus.iBlockIn = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk128("hold_stable", bus.oBlockOut, held);
      chk1("hold_in_ready", bus.oInReady, 1'b0);
      chk1("hold_valid", bus.oOutValid, 1'b1);
    end
    bus.iOutReady = 1'b1;
    #1;
    chk1("release_in_ready", bus.oInReady, 1'b1);
    @(posedge clk);
    wait_out(lat);
    chk_int("back_to_back_latency", lat, 6);
    chk128("back_to_back_block", bus.oBlockOut, fwd_model(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0));
    consume();

    // Reset during SUB beat 2
    send(128'hdeadbeefcafebabe0123456789abcdef);
    @(negedge clk);
    bus.iInValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("pre_reset_in_ready", bus.oInReady, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("midreset_valid", bus.oOutValid, 1'b0);
    chk128("midreset_block", bus.oBlockOut, 128'h0);
    chk1("midreset_in_ready", bus.oInReady, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk1("no_partial_output", bus.oOutValid, 1'b0);
    send(128'h3243f6a8885a308d313198a2e0370734);
    wait_out(lat);
    chk_int("post_reset_latency", lat, 6);
    exp_b = fwd_model(128'h3243f6a8885a308d313198a2e0370734);
    chk128("post_reset_block", bus.oBlockOut, exp_b);
    consume();

    run_stream(50, 1'b1, 1'b0);
    run_stream(256, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
